// File: rtl/demux1to2_buf.sv
// demux1to2_buf: steers one valid/ready stream into one of two
// buffered output streams, one registered slot per output.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid, in_ready     upstream handshake
//   in_select              0 -> out1, 1 -> out2
//   in_data [n-1:0]        upstream word
//   outX_valid, outX_ready downstream handshake per output
//   outX_data [n-1:0]      slot contents per output
//   count1, count2 [cw-1:0] delivered-word counters (wrap)
module demux1to2_buf #(
  parameter int n  = 32,
  parameter int cw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_select,
  input  logic [n-1:0]  in_data,
  output logic          in_ready,
  output logic          out1_valid,
  output logic [n-1:0]  out1_data,
  input  logic          out1_ready,
  output logic          out2_valid,
  output logic [n-1:0]  out2_data,
  input  logic          out2_ready,
  output logic [cw-1:0] count1,
  output logic [cw-1:0] count2
);

  logic         full1;
  logic         full2;
  logic [n-1:0] data1;
  logic [n-1:0] data2;

  logic sel_free;
  logic in_hs;
  logic ld1;
  logic ld2;
  logic dq1;
  logic dq2;

  // The selected slot can take a word if it is empty or is
  // being drained at this same edge.
  always_comb begin
    sel_free = 1'b0;
    unique case (1'b1)
      in_select:  sel_free = !full2 || out2_ready;
      !in_select: sel_free = !full1 || out1_ready;
    endcase
  end

  assign in_ready = !rst && sel_free;
  assign in_hs    = in_valid && in_ready;
  assign ld1      = in_hs && !in_select;
  assign ld2      = in_hs && in_select;
  assign dq1      = full1 && out1_ready;
  assign dq2      = full2 && out2_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full1  <= 1'b0;
      full2  <= 1'b0;
      data1  <= '0;
      data2  <= '0;
      count1 <= '0;
      count2 <= '0;
    end else begin
      // A load wins over a drain so a simultaneous
      // replace keeps the slot full.
      if (ld1) begin
        data1 <= in_data;
        full1 <= 1'b1;
      end else if (dq1) begin
        full1 <= 1'b0;
      end

      if (ld2) begin
        data2 <= in_data;
        full2 <= 1'b1;
      end else if (dq2) begin
        full2 <= 1'b0;
      end

      if (dq1) count1 <= count1 + cw'(1);
      if (dq2) count2 <= count2 + cw'(1);
    end
  end

  assign out1_valid = full1;
  assign out2_valid = full2;
  assign out1_data  = data1;
  assign out2_data  = data2;

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb_demux1to2_buf: directed checks of the 1-to-2 buffered demux
// with n=32 and cw=4.
module tb_demux1to2_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_select;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out1_valid;
  logic [31:0] out1_data;
  logic        out1_ready;
  logic        out2_valid;
  logic [31:0] out2_data;
  logic        out2_ready;
  logic [3:0]  count1;
  logic [3:0]  count2;

  int checks   = 0;
  int failures = 0;

  demux1to2_buf #(.n(32), .cw(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_select  (in_select),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out2_valid (out2_valid),
    .out2_data  (out2_data),
    .out2_ready (out2_ready),
    .count1     (count1),
    .count2     (count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_select  = 1'b0;
    in_data    = '0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    tick();
    tick();
    chk("rdy_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_v2", 32'(out2_valid), 32'd0);
    chk("rst_c1", 32'(count1), 32'd0);
    chk("rst_c2", 32'(count2), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_d1", out1_data, 32'h0);
    chk("rst_d2", out2_data, 32'h0);

    // Basic routing to both outputs
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    in_valid   = 1'b1;
    in_select  = 1'b0;
    in_data    = 32'hAAAA0001;
    tick();
    chk("b_v1", 32'(out1_valid), 32'd1);
    chk("b_d1", out1_data, 32'hAAAA0001);
    chk("b_c1_pre", 32'(count1), 32'd0);
    in_select = 1'b1;
    in_data   = 32'hBBBB0002;
    tick();
    chk("b_v2", 32'(out2_valid), 32'd1);
    chk("b_d2", out2_data, 32'hBBBB0002);
    chk("b_c1", 32'(count1), 32'd1);
    chk("b_v1_off", 32'(out1_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("b_c2", 32'(count2), 32'd1);
    chk("b_v2_off", 32'(out2_valid), 32'd0);

    // Backpressure on out1, then replace in one edge
    out1_ready = 1'b0;
    in_valid   = 1'b1;
    in_select  = 1'b0;
    in_data    = 32'h11111111;
    tick();
    in_data = 32'h22222222;
    #1;
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    tick();
    chk("bp_hold", out1_data, 32'h11111111);
    chk("bp_v1", 32'(out1_valid), 32'd1);
    chk("bp_c1", 32'(count1), 32'd1);
    out1_ready = 1'b1;
    #1;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    chk("rep_d1", out1_data, 32'h22222222);
    chk("rep_v1", 32'(out1_valid), 32'd1);
    chk("rep_c1", 32'(count1), 32'd2);

    // out1 stalled full, out2 still accepts
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    in_select  = 1'b1;
    in_data    = 32'h33333333;
    #1;
    chk("ind_rdy", 32'(in_ready), 32'd1);
    tick();
    chk("ind_d2", out2_data, 32'h33333333);
    chk("ind_v2", 32'(out2_valid), 32'd1);
    chk("ind_d1", out1_data, 32'h22222222);
    chk("ind_v1", 32'(out1_valid), 32'd1);
    chk("ind_c1", 32'(count1), 32'd2);
    in_valid = 1'b0;

    // Reset with both slots full discards both words
    rst = 1'b1;
    #1;
    chk("mr_rdy", 32'(in_ready), 32'd0);
    tick();
    rst        = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    #1;
    chk("mr_v1", 32'(out1_valid), 32'd0);
    chk("mr_v2", 32'(out2_valid), 32'd0);
    chk("mr_c1", 32'(count1), 32'd0);
    chk("mr_c2", 32'(count2), 32'd0);
    tick();
    tick();
    chk("mr_c1_after", 32'(count1), 32'd0);
    chk("mr_c2_after", 32'(count2), 32'd0);

    // Counter wrap at cw=4: 17 out2 handshakes
    in_valid  = 1'b1;
    in_select = 1'b1;
    in_data   = 32'h100;
    tick();
    chk("w_load", out2_data, 32'h100);
    for (int i = 1; i <= 15; i++) begin
      in_data = 32'h100 + 32'(i);
      tick();
    end
    chk("w_c15", 32'(count2), 32'd15);
    chk("w_d15", out2_data, 32'h10F);
    in_data = 32'h110;
    tick();
    chk("w_c0", 32'(count2), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("w_c1", 32'(count2), 32'd1);
    chk("w_v2", 32'(out2_valid), 32'd0);
    chk("w_d_keep", out2_data, 32'h110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1to2_buf.md
DEMUX1TO2_BUF -- requirements
Module: demux1to2_buf

Interface
REQ-001 The block SHALL have parameter n, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter cw, default 16, giving the width of each transfer counter.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  the upstream word is present.
REQ-006 in_select  input  1  the destination of the upstream word: 0 routes to out1, 1 routes to out2.
REQ-007 in_data  input  n  the upstream word.
REQ-008 in_ready  output  1  the block accepts the upstream word this cycle.
REQ-009 out1_valid, out2_valid  output  1 each  the output slot holds a word.
REQ-010 out1_data, out2_data  output  n each  the output slot contents.
REQ-011 out1_ready, out2_ready  input  1 each  the downstream consumer takes the word.
REQ-012 count1, count2  output  cw each  the number of words delivered on each output, modulo 2^cw.

Function
REQ-013 The block SHALL be the inverse of the datapath 2-to-1 mux: it steers one input stream into one of two output streams.
REQ-014 Each output SHALL have a one-entry holding register (slot) with a full flag; outX_valid SHALL equal slot X full.
REQ-015 An input handshake SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-016 An output X handshake SHALL occur on a rising edge where outX_valid=1 and outX_ready=1.
REQ-017 in_ready SHALL be combinational and equal !rst && (!slotS_full || outS_ready), where S is the slot selected by the current in_select.
REQ-018 in_ready SHALL NOT depend on in_valid.
REQ-019 On an input handshake, in_data SHALL be written to slot S, and slot S full SHALL be 1 after the edge.
REQ-020 Latency SHALL be one cycle: a word accepted at edge k drives outS_valid=1 with that data from edge k onward, i.e. it is visible in the following cycle.
REQ-021 On an output handshake with no simultaneous input to that slot, the slot full flag SHALL clear.
REQ-022 If an output handshake and an input handshake target the same slot at the same edge, the new word SHALL replace the old one, the full flag SHALL stay 1, and no word SHALL be lost or duplicated.
REQ-023 The two slots SHALL operate independently: either output may drain while the input loads the other slot at the same edge.
REQ-024 While outX_valid=1 and outX_ready=0, outX_data SHALL hold stable.
REQ-025 A slot that is empty SHALL retain its last data value; consumers SHALL ignore data while valid=0.
REQ-026 countX SHALL increment by 1 on each output X handshake, wrapping from 2^cw-1 to 0.
REQ-027 in_select SHALL only be meaningful when in_valid=1; words on out1 and on out2 SHALL each keep their input order.

Reset
REQ-028 While rst=1 at a rising edge, both full flags SHALL clear, outX_data SHALL be set to 0, and count1 and count2 SHALL be set to 0.
REQ-029 While rst=1, in_ready SHALL be 0 and no handshake SHALL be counted.
REQ-030 If rst is asserted mid-operation, buffered words SHALL be discarded without delivery.
REQ-031 On the first edge with rst=0, the block SHALL accept a word if in_valid=1.

Verification
REQ-032 Reset then idle -> out1_valid=out2_valid=0, count1=count2=0, in_ready=1, both data outputs 0x00000000.
REQ-033 Send 0xAAAA0001 with select 0 and 0xBBBB0002 with select 1, both readies 1 -> each word appears on the correct output one cycle later; count1=1 and count2=1.
REQ-034 Hold out1_ready=0 and send 0x11111111 to out1, then offer 0x22222222 to out1 -> in_ready=0 and out1_data is held at 0x11111111. Then raise out1_ready -> the same edge delivers 0x11111111 and loads 0x22222222.
REQ-035 Stall out1 full and send 0x33333333 to out2 -> in_ready=1, out2 receives the word, and out1 is unchanged.
REQ-036 Set cw=4 and perform 17 out2 handshakes -> count2 reads 15, then 0, then 1.
REQ-037 With both slots full, assert rst for one cycle -> both valids 0 and both counts 0; neither buffered word is ever delivered.
